// File: rtl/usb_controller_pkg.sv
// Shared types and constants for the USB FIFO host-link front end.
package usb_controller_pkg;

    typedef enum logic [4:0] {
        ST_IDLE      = 5'd0,
        ST_HDR_RD    = 5'd1,
        ST_HDR_REC   = 5'd2,
        ST_DAT_WAIT  = 5'd3,
        ST_DAT_RD    = 5'd4,
        ST_DAT_REC   = 5'd5,
        ST_ACK_WAIT  = 5'd6,
        ST_ACK_SETUP = 5'd7,
        ST_ACK_WR    = 5'd8,
        ST_ACK_HOLD  = 5'd9
    } state_e;

    localparam int FRAME_PAYLOAD_BYTES = 64;
    localparam int RD_LOW_CYCLES_DEF   = 4;
    localparam int RECOVER_CYCLES_DEF  = 4;
    localparam int WR_LOW_CYCLES_DEF   = 3;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } panel_match_t;

    // Lowest-indexed switch nibble equal to the header panel ID wins.
    function automatic panel_match_t find_panel(input logic [3:0] id, input logic [15:0] sw);
        panel_match_t m;
        m = '0;
        for (int i = 3; i >= 0; i--) begin
            if (sw[4*i +: 4] == id) begin
                m.hit = 1'b1;
                m.idx = 2'(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/usb_input_sync.sv
// Two-flop synchroniser for asynchronous inputs, with configurable width and reset value.
module usb_input_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/usb_controller.sv
// FT245-style FIFO front end: reads 65-byte frames, emits 32-bit chunk writes,
// and echoes the header byte back as an acknowledge.
module usb_controller
    import usb_controller_pkg::*;
#(
    parameter int RD_LOW_CYCLES  = RD_LOW_CYCLES_DEF,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF,
    parameter int WR_LOW_CYCLES  = WR_LOW_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] panel_switches_raw,
    input  logic        rxf_n_raw,
    input  logic        txe_n_raw,
    input  logic [7:0]  data_bus_in_raw,
    output logic [7:0]  data_bus_out,
    output logic        rd_n,
    output logic        wr_n,
    output logic        data_out_enable,
    output logic [31:0] chunk_data,
    output logic [3:0]  chunk_addr,
    output logic        chunk_write_enable,
    output logic [3:0]  row_addr,
    output logic [1:0]  panel_addr,
    output logic [4:0]  state_out
);

    localparam logic [7:0] RD_LOAD  = 8'(RD_LOW_CYCLES - 1);
    localparam logic [7:0] REC_LOAD = 8'(RECOVER_CYCLES - 1);
    localparam logic [7:0] WR_LOAD  = 8'(WR_LOW_CYCLES - 1);
    localparam logic [6:0] LAST_BYTE = 7'(FRAME_PAYLOAD_BYTES);

    logic        rxf_n_s, txe_n_s;
    logic [15:0] sw_s;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  data_q;
    logic [7:0]  hdr_q, hdr_d;
    logic [6:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] sh_q, sh_d;
    logic        accept_q, accept_d;
    logic [31:0] chunk_data_q, chunk_data_d;
    logic [3:0]  chunk_addr_q, chunk_addr_d;
    logic        cwe_q, cwe_d;
    logic [3:0]  row_q, row_d;
    logic [1:0]  panel_q, panel_d;
    logic [7:0]  dbo_q, dbo_d;
    logic        doe_q, doe_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    panel_match_t match;

    usb_input_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_rxf (
        .clk_i(clk), .rst_i(reset), .d_i(rxf_n_raw), .q_o(rxf_n_s)
    );
    usb_input_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_txe (
        .clk_i(clk), .rst_i(reset), .d_i(txe_n_raw), .q_o(txe_n_s)
    );
    usb_input_sync #(.WIDTH(16), .RESET_VAL(16'h0000)) u_sync_sw (
        .clk_i(clk), .rst_i(reset), .d_i(panel_switches_raw), .q_o(sw_s)
    );

    assign match = find_panel(hdr_q[7:4], sw_s);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hdr_d        = hdr_q;
        byte_cnt_d   = byte_cnt_q;
        sh_d         = sh_q;
        accept_d     = accept_q;
        chunk_data_d = chunk_data_q;
        chunk_addr_d = chunk_addr_q;
        cwe_d        = 1'b0;
        row_d        = row_q;
        panel_d      = panel_q;
        dbo_d        = dbo_q;
        doe_d        = doe_q;

        case (state_q)
            ST_IDLE: begin
                byte_cnt_d = '0;
                if (!rxf_n_s) begin
                    state_d = ST_HDR_RD;
                    cnt_d   = RD_LOAD;
                end
            end
            ST_HDR_RD: begin
                if (cnt_q == 8'd0) begin
                    hdr_d   = data_q;
                    state_d = ST_HDR_REC;
                    cnt_d   = REC_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HDR_REC: begin
                if (cnt_q == REC_LOAD) begin
                    row_d    = hdr_q[3:0];
                    accept_d = match.hit;
                    if (match.hit) panel_d = match.idx;
                end
                if (cnt_q == 8'd0) state_d = ST_DAT_WAIT;
                else               cnt_d   = cnt_q - 8'd1;
            end
            ST_DAT_WAIT: begin
                if (!rxf_n_s) begin
                    state_d = ST_DAT_RD;
                    cnt_d   = RD_LOAD;
                end
            end
            ST_DAT_RD: begin
                if (cnt_q == 8'd0) begin
                    sh_d       = {sh_q[23:0], data_q};
                    byte_cnt_d = byte_cnt_q + 7'd1;
                    state_d    = ST_DAT_REC;
                    cnt_d      = REC_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DAT_REC: begin
                // byte_cnt_q counts bytes received, so a multiple of four closes a chunk
                if (cnt_q == REC_LOAD && accept_q && byte_cnt_q[1:0] == 2'd0) begin
                    cwe_d        = 1'b1;
                    chunk_data_d = sh_q;
                    chunk_addr_d = byte_cnt_q[5:2] - 4'd1;
                end
                if (cnt_q == 8'd0) state_d = (byte_cnt_q == LAST_BYTE) ? ST_ACK_WAIT : ST_DAT_WAIT;
                else               cnt_d   = cnt_q - 8'd1;
            end
            ST_ACK_WAIT: begin
                if (!txe_n_s) begin
                    dbo_d   = hdr_q;
                    doe_d   = 1'b1;
                    state_d = ST_ACK_SETUP;
                end
            end
            ST_ACK_SETUP: begin
                state_d = ST_ACK_WR;
                cnt_d   = WR_LOAD;
            end
            ST_ACK_WR: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_ACK_HOLD;
                    cnt_d   = REC_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACK_HOLD: begin
                doe_d = 1'b0;
                if (cnt_q == 8'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        rd_n_d = !(state_d == ST_HDR_RD || state_d == ST_DAT_RD);
        wr_n_d = (state_d != ST_ACK_WR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            data_q       <= '0;
            hdr_q        <= '0;
            byte_cnt_q   <= '0;
            sh_q         <= '0;
            accept_q     <= 1'b0;
            chunk_data_q <= '0;
            chunk_addr_q <= '0;
            cwe_q        <= 1'b0;
            row_q        <= '0;
            panel_q      <= '0;
            dbo_q        <= '0;
            doe_q        <= 1'b0;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_q       <= data_bus_in_raw;
            hdr_q        <= hdr_d;
            byte_cnt_q   <= byte_cnt_d;
            sh_q         <= sh_d;
            accept_q     <= accept_d;
            chunk_data_q <= chunk_data_d;
            chunk_addr_q <= chunk_addr_d;
            cwe_q        <= cwe_d;
            row_q        <= row_d;
            panel_q      <= panel_d;
            dbo_q        <= dbo_d;
            doe_q        <= doe_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
        end
    end

    assign data_bus_out       = dbo_q;
    assign rd_n               = rd_n_q;
    assign wr_n               = wr_n_q;
    assign data_out_enable    = doe_q;
    assign chunk_data         = chunk_data_q;
    assign chunk_addr         = chunk_addr_q;
    assign chunk_write_enable = cwe_q;
    assign row_addr           = row_q;
    assign panel_addr         = panel_q;
    assign state_out          = state_q;

endmodule

// File: tb/tb_usb_controller.sv
// Scoreboard bench for usb_controller: a host FIFO model feeds frames, a frame-level
// reference model predicts chunk writes and acknowledges, and a monitor checks them.
module tb_usb_controller;

    localparam int RD_LOW = 4;
    localparam int WR_LOW = 3;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  a;
        logic [3:0]  r;
        logic [1:0]  p;
    } chunk_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] panel_switches_raw;
    logic        rxf_n_raw;
    logic        txe_n_raw;
    logic [7:0]  data_bus_in_raw;
    logic [7:0]  data_bus_out;
    logic        rd_n, wr_n, data_out_enable, chunk_write_enable;
    logic [31:0] chunk_data;
    logic [3:0]  chunk_addr, row_addr;
    logic [1:0]  panel_addr;
    logic [4:0]  state_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] rxq[$];
    int         rx_cnt = 0;
    logic       stall = 1'b0;
    logic       force_rxf_low = 1'b0;
    int         popped = 0, frame_base = 0, stall_at = 0;
    int         rd_pulses = 0, bad_rd = 0, ack_seen = 0;
    int         pulses_base = 0, bad_base = 0, ack_target = 0;
    logic [7:0] payload[64];
    chunk_t     exp_chunk_q[$];
    logic [7:0] exp_ack_q[$];

    assign rxf_n_raw = !(force_rxf_low || (rx_cnt != 0 && !stall));

    always #10 clk = ~clk;

    usb_controller dut (
        .clk               (clk),
        .reset             (reset),
        .panel_switches_raw(panel_switches_raw),
        .rxf_n_raw         (rxf_n_raw),
        .txe_n_raw         (txe_n_raw),
        .data_bus_in_raw   (data_bus_in_raw),
        .data_bus_out      (data_bus_out),
        .rd_n              (rd_n),
        .wr_n              (wr_n),
        .data_out_enable   (data_out_enable),
        .chunk_data        (chunk_data),
        .chunk_addr        (chunk_addr),
        .chunk_write_enable(chunk_write_enable),
        .row_addr          (row_addr),
        .panel_addr        (panel_addr),
        .state_out         (state_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_rd_n"},  64'(rd_n), 64'd1);
        check({pfx, "_wr_n"},  64'(wr_n), 64'd1);
        check({pfx, "_doe"},   64'(data_out_enable), 64'd0);
        check({pfx, "_dbo"},   64'(data_bus_out), 64'd0);
        check({pfx, "_cdata"}, 64'(chunk_data), 64'd0);
        check({pfx, "_caddr"}, 64'(chunk_addr), 64'd0);
        check({pfx, "_cwe"},   64'(chunk_write_enable), 64'd0);
        check({pfx, "_row"},   64'(row_addr), 64'd0);
        check({pfx, "_panel"}, 64'(panel_addr), 64'd0);
        check({pfx, "_state"}, 64'(state_out), 64'd0);
    endtask

    // Reference model: the frame-level rules, then hand the bytes to the host FIFO.
    task automatic prepare_frame(input logic [7:0] hdr);
        int     p;
        chunk_t e;
        p = -1;
        for (int i = 0; i < 4; i++)
            if (p < 0 && panel_switches_raw[4*i +: 4] == hdr[7:4]) p = i;
        if (p >= 0) begin
            for (int c = 0; c < 16; c++) begin
                e.d = {payload[4*c], payload[4*c+1], payload[4*c+2], payload[4*c+3]};
                e.a = 4'(c);
                e.r = hdr[3:0];
                e.p = 2'(p);
                exp_chunk_q.push_back(e);
            end
        end
        exp_ack_q.push_back(hdr);
        frame_base  = popped;
        pulses_base = rd_pulses;
        bad_base    = bad_rd;
        ack_target  = ack_seen + 1;
        rxq.push_back(hdr);
        for (int i = 0; i < 64; i++) rxq.push_back(payload[i]);
        data_bus_in_raw = rxq[0];
        rx_cnt = rxq.size();
    endtask

    task automatic finish_frame(input string name);
        for (int k = 0; k < 3000 && ack_seen < ack_target; k++) @(negedge clk);
        check({name, "_ack_done"}, 64'(ack_seen >= ack_target), 64'd1);
        repeat (2) @(negedge clk);
        check({name, "_chunks_left"}, 64'(exp_chunk_q.size()), 64'd0);
        check({name, "_rd_pulses"}, 64'(rd_pulses - pulses_base), 64'd65);
        check({name, "_rd_width"}, 64'(bad_rd - bad_base), 64'd0);
    endtask

    task automatic host_reader();
        logic [7:0] b;
        int         bad;
        forever begin
            @(negedge rd_n);
            @(posedge rd_n or posedge reset);
            if (reset || rx_cnt == 0) continue;
            b = rxq.pop_front();
            rx_cnt = rxq.size();
            data_bus_in_raw = (rx_cnt > 0) ? rxq[0] : 8'h00;
            popped++;
            if (stall_at != 0 && popped - frame_base == stall_at) begin
                stall = 1'b1;
                bad = 0;
                repeat (5) @(negedge clk);
                for (int k = 0; k < 45; k++) begin
                    @(negedge clk);
                    if (rd_n !== 1'b1 || state_out !== 5'd3) bad++;
                end
                stall = 1'b0;
                stall_at = 0;
                check("rxf_stall_hold", 64'(bad), 64'd0);
            end
        end
    endtask

    task automatic monitor();
        logic   prev_wr, prev_rd, prev_doe, prev2_doe, chk_doe_low;
        int     rd_len, wr_len;
        chunk_t e;
        prev_wr = 1'b1; prev_rd = 1'b1; prev_doe = 1'b0; prev2_doe = 1'b0;
        chk_doe_low = 1'b0; rd_len = 0; wr_len = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_wr = 1'b1; prev_rd = 1'b1; prev_doe = 1'b0; prev2_doe = 1'b0;
                chk_doe_low = 1'b0; rd_len = 0; wr_len = 0;
                continue;
            end
            if (chk_doe_low) begin
                check("ack_doe_trail_off", 64'(data_out_enable), 64'd0);
                chk_doe_low = 1'b0;
            end
            if (chunk_write_enable) begin
                if (exp_chunk_q.size() == 0) begin
                    check("unexpected_chunk_write", 64'd1, 64'd0);
                end else begin
                    e = exp_chunk_q.pop_front();
                    check("chunk_data_addr_row_panel",
                          64'({chunk_data, chunk_addr, row_addr, panel_addr}), 64'(e));
                end
            end
            if (!rd_n) rd_len++;
            else if (!prev_rd) begin
                rd_pulses++;
                if (rd_len != RD_LOW) bad_rd++;
                rd_len = 0;
            end
            if (!wr_n) begin
                wr_len++;
                if (prev_wr) begin
                    check("ack_doe_lead", 64'({prev2_doe, prev_doe, data_out_enable}), 64'b011);
                    if (exp_ack_q.size() == 0) check("unexpected_ack", 64'd1, 64'd0);
                    else check("ack_byte", 64'(data_bus_out), 64'(exp_ack_q.pop_front()));
                end
            end else if (!prev_wr) begin
                check("ack_wr_width", 64'(wr_len), 64'(WR_LOW));
                check("ack_doe_trail_on", 64'(data_out_enable), 64'd1);
                chk_doe_low = 1'b1;
                wr_len = 0;
                ack_seen++;
            end
            prev2_doe = prev_doe;
            prev_doe  = data_out_enable;
            prev_wr   = wr_n;
            prev_rd   = rd_n;
        end
    endtask

    initial begin
        int         lat, bad, idx;
        logic [7:0] hdr;

        reset = 1'b1;
        panel_switches_raw = 16'hFDEC;
        txe_n_raw = 1'b0;
        data_bus_in_raw = 8'h00;
        force_rxf_low = 1'b1;
        fork
            monitor();
            host_reader();
        join_none

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        lat = 0;
        for (int k = 0; k < 20 && rd_n === 1'b1; k++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("rd_fall_latency", 64'(lat >= 2 && rd_n === 1'b0), 64'd1);

        @(negedge clk);
        reset = 1'b1;
        force_rxf_low = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 64; i++) payload[i] = 8'h23;
        prepare_frame(8'h23);
        finish_frame("discard");
        check("discard_row_panel", 64'({row_addr, panel_addr}), 64'({4'h3, 2'd0}));

        for (int i = 0; i < 64; i++) payload[i] = 8'(i);
        prepare_frame(8'hE5);
        finish_frame("accept");

        panel_switches_raw = 16'h7777;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 64; i++) payload[i] = 8'($urandom);
        prepare_frame(8'h7A);
        finish_frame("dup_ids");

        for (int f = 0; f < 5; f++) begin
            panel_switches_raw = 16'($urandom);
            repeat (4) @(negedge clk);
            idx = int'($urandom_range(0, 3));
            hdr = 8'($urandom);
            if ($urandom_range(0, 1) == 1) hdr[7:4] = panel_switches_raw[4*idx +: 4];
            for (int i = 0; i < 64; i++) payload[i] = 8'($urandom);
            prepare_frame(hdr);
            finish_frame("random");
        end

        panel_switches_raw = 16'hFDEC;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 64; i++) payload[i] = 8'($urandom);
        stall_at = 12;
        prepare_frame(8'hD2);
        finish_frame("rxf_stall");

        txe_n_raw = 1'b1;
        for (int i = 0; i < 64; i++) payload[i] = 8'($urandom);
        prepare_frame(8'hC9);
        for (int k = 0; k < 3000 && state_out !== 5'd6; k++) @(negedge clk);
        check("txe_stall_reached", 64'(state_out), 64'd6);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (state_out !== 5'd6 || wr_n !== 1'b1) bad++;
        end
        check("txe_stall_hold", 64'(bad), 64'd0);
        txe_n_raw = 1'b0;
        finish_frame("txe_stall");

        for (int i = 0; i < 64; i++) payload[i] = 8'($urandom);
        prepare_frame(8'hF1);
        for (int k = 0; k < 3000 && popped - frame_base < 22; k++) @(negedge clk);
        check("midframe_reached", 64'(popped - frame_base >= 22), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rxq.delete();
        rx_cnt = 0;
        data_bus_in_raw = 8'h00;
        exp_chunk_q.delete();
        exp_ack_q.delete();
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 64; i++) payload[i] = 8'($urandom);
        prepare_frame(8'hC6);
        finish_frame("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
